// File: rtl/twos_complement_serial_word.sv
// twos_complement_serial_word: word-framed LSB-first serial pass / one's / two's complement unit
module twos_complement_serial_word #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic [1:0]       mode,
    input  logic             sync,
    output logic             out_valid,
    output logic             out_bit,
    output logic             word_done,
    output logic [WIDTH-1:0] out_word,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {SCAN, INVERT} state_t;
    state_t state, state_cur, state_nxt;
    logic [CW-1:0] bit_cnt, cnt_cur;
    logic [1:0] mode_q, mode_cur;
    logic [WIDTH-1:0] asm_q;
    logic last, res_bit;
    // sync and word start both behave as bit 0 with a fresh mode and SCAN
    always_comb begin
        cnt_cur   = sync ? '0 : bit_cnt;
        last      = cnt_cur == CW'(WIDTH - 1);
        mode_cur  = cnt_cur == '0 ? mode : mode_q;
        state_cur = cnt_cur == '0 ? SCAN : state;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= SCAN;
        else        state <= state_nxt;
    always_comb state_nxt = !in_valid ? (sync ? SCAN : state) : (in_bit ? INVERT : state_cur);
    always_comb res_bit = mode_cur == 2'b00 ? in_bit :
                          mode_cur == 2'b01 ? ~in_bit : in_bit ^ (state_cur == INVERT);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= '0;
            mode_q    <= 2'b10;
            asm_q     <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            word_done <= 1'b0;
            out_word  <= '0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            word_done <= in_valid && last;
            if (sync) asm_q <= '0;
            if (in_valid) begin
                bit_cnt        <= last ? '0 : cnt_cur + CW'(1);
                mode_q         <= mode_cur;
                asm_q[cnt_cur] <= res_bit;
                out_bit        <= res_bit;
                if (last) begin
                    out_word <= {res_bit, asm_q[WIDTH-2:0]};
                    overflow <= mode_cur[1] && state_cur == SCAN && in_bit;
                end
            end else if (sync) begin
                bit_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_twos_complement_serial_word.sv
// tb_twos_complement_serial_word: randomized self-checking bench against a word-level arithmetic model
module tb_twos_complement_serial_word;
    localparam int W = 16;
    logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, in_bit = 1'b0, sync = 1'b0;
    logic [1:0] mode = 2'b10;
    logic out_valid, out_bit, word_done, overflow;
    logic [W-1:0] out_word;
    int checks = 0, errors = 0;
    int ov_cnt = 0, wd_cnt = 0, wd_at = 0, hold_err = 0;
    logic prev_ob = 1'b0;
    logic obits[$];

    twos_complement_serial_word #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .mode(mode), .sync(sync),
        .out_valid(out_valid), .out_bit(out_bit), .word_done(word_done), .out_word(out_word),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid) begin
            ov_cnt++;
            obits.push_back(out_bit);
        end
        if (word_done) begin
            wd_cnt++;
            wd_at = ov_cnt;
        end
        if (!out_valid && out_bit !== prev_ob) hold_err++;
        prev_ob = out_bit;
    end

    function automatic logic [W-1:0] model(input logic [W-1:0] w, input logic [1:0] m);
        return m == 2'b00 ? w : m == 2'b01 ? ~w : W'(0 - w);
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] w, input logic [1:0] m);
        return m[1] && w == 16'h8000;
    endfunction

    function automatic logic [W-1:0] tail_word();
        logic [W-1:0] w;
        if (obits.size() < W) return 'x;
        for (int i = 0; i < W; i++) w[i] = obits[obits.size() - W + i];
        return w;
    endfunction

    task automatic drive(input logic v, input logic b, input logic [1:0] m, input logic s);
        @(posedge clk);
        #2;
        in_valid = v;
        in_bit   = b;
        mode     = m;
        sync     = s;
    endtask

    task automatic idle();
        repeat (2) drive(1'b0, 1'b0, 2'b10, 1'b0);
    endtask

    task automatic clear();
        ov_cnt = 0;
        wd_cnt = 0;
        wd_at  = 0;
        obits.delete();
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic [1:0] m, input logic [1:0] m2,
                             input int chg, input int maxgap, input logic first_sync);
        for (int i = 0; i < W; i++) begin
            if (maxgap > 0)
                repeat ($urandom_range(maxgap, 0)) drive(1'b0, 1'b0, i < chg ? m : m2, 1'b0);
            drive(1'b1, w[i], i < chg ? m : m2, i == 0 && first_sync);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({out_valid, out_bit, word_done, overflow, out_word} !== '0) begin
            errors++;
            $display("FAIL reset_state outputs=%b required all zero",
                     {out_valid, out_bit, word_done, overflow, out_word});
        end
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic test_modes();
        logic [1:0] modes[4] = '{2'b10, 2'b01, 2'b00, 2'b11};
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 2'b10, 1'b0);
            clear();
            send_word(16'h5772, modes[k], modes[k], W, 0, 1'b0);
            idle();
            checks++;
            if (out_word !== model(16'h5772, modes[k]) || overflow !== 1'b0) begin
                errors++;
                $display("FAIL mode_word mode=%b out_word=%h ovf=%b required %h ovf=0",
                         modes[k], out_word, overflow, model(16'h5772, modes[k]));
            end
            checks++;
            if (tail_word() !== model(16'h5772, modes[k]) || ov_cnt != W) begin
                errors++;
                $display("FAIL mode_bits mode=%b serial=%h count=%0d required %h count=%0d",
                         modes[k], tail_word(), ov_cnt, model(16'h5772, modes[k]), W);
            end
            checks++;
            if (wd_cnt != 1 || wd_at != W) begin
                errors++;
                $display("FAIL mode_done mode=%b pulses=%0d at=%0d required 1 at %0d",
                         modes[k], wd_cnt, wd_at, W);
            end
        end
    endtask

    task automatic test_mode_change();
        clear();
        send_word(16'h5772, 2'b10, 2'b00, 7, 0, 1'b0);
        idle();
        checks++;
        if (out_word !== 16'hA88E || tail_word() !== 16'hA88E) begin
            errors++;
            $display("FAIL mode_change out_word=%h serial=%h required a88e", out_word, tail_word());
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] words[3] = '{16'h8000, 16'h0000, 16'h0001};
        for (int k = 0; k < 3; k++) begin
            clear();
            send_word(words[k], 2'b10, 2'b10, W, 0, 1'b0);
            idle();
            checks++;
            if (out_word !== model(words[k], 2'b10) || overflow !== model_ovf(words[k], 2'b10)) begin
                errors++;
                $display("FAIL overflow in=%h out_word=%h ovf=%b required %h ovf=%b", words[k],
                         out_word, overflow, model(words[k], 2'b10), model_ovf(words[k], 2'b10));
            end
        end
    endtask

    task automatic test_stalls();
        int h0;
        logic [W-1:0] w;
        logic [1:0] m;
        for (int k = 0; k < 5; k++) begin
            w = k == 0 ? 16'h5772 : W'($urandom);
            m = k == 0 ? 2'b10 : 2'($urandom);
            clear();
            h0 = hold_err;
            send_word(w, m, m, W, 3, 1'b0);
            idle();
            checks++;
            if (out_word !== model(w, m) || overflow !== model_ovf(w, m) || tail_word() !== model(w, m)) begin
                errors++;
                $display("FAIL stall_word in=%h mode=%b out_word=%h serial=%h required %h",
                         w, m, out_word, tail_word(), model(w, m));
            end
            checks++;
            if (ov_cnt != W || wd_cnt != 1 || hold_err != h0) begin
                errors++;
                $display("FAIL stall_count valid=%0d done=%0d hold_err=%0d required %0d 1 0",
                         ov_cnt, wd_cnt, hold_err - h0, W);
            end
        end
    endtask

    task automatic test_sync();
        clear();
        repeat (5) drive(1'b1, 1'b1, 2'b10, 1'b0);
        send_word(16'h5772, 2'b10, 2'b10, W, 0, 1'b1);
        idle();
        checks++;
        if (out_word !== 16'hA88E || wd_cnt != 1 || ov_cnt != W + 5) begin
            errors++;
            $display("FAIL sync out_word=%h done=%0d valid=%0d required a88e 1 %0d",
                     out_word, wd_cnt, ov_cnt, W + 5);
        end
    endtask

    task automatic test_async_reset();
        clear();
        send_word(16'h1234, 2'b00, 2'b00, W, 0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, i[0] ^ i[2], 2'b10, 1'b0);
        @(posedge clk);
        #3 reset = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_bit, word_done, overflow, out_word} !== '0) begin
            errors++;
            $display("FAIL async_reset outputs=%b required all zero",
                     {out_valid, out_bit, word_done, overflow, out_word});
        end
        @(posedge clk);
        #2 reset = 1'b1;
        clear();
        send_word(16'h0003, 2'b10, 2'b10, W, 0, 1'b0);
        idle();
        checks++;
        if (out_word !== 16'hFFFD || wd_cnt != 1) begin
            errors++;
            $display("FAIL after_reset out_word=%h done=%0d required fffd 1", out_word, wd_cnt);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 8;
        logic exp_bits[$];
        logic [W-1:0] w, r, last_r;
        logic [1:0] m;
        logic last_o;
        int bad = 0;
        clear();
        for (int k = 0; k < N; k++) begin
            w = k == N - 1 ? 16'h8000 : W'($urandom);
            m = k == N - 1 ? 2'b11 : 2'($urandom);
            r = model(w, m);
            last_r = r;
            last_o = model_ovf(w, m);
            for (int i = 0; i < W; i++) exp_bits.push_back(r[i]);
            send_word(w, m, m, W, 0, 1'b0);
        end
        idle();
        if (obits.size() != exp_bits.size()) bad = -1;
        else for (int i = 0; i < exp_bits.size(); i++) if (obits[i] !== exp_bits[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_bits wrong=%0d got_len=%0d required 0 wrong len %0d",
                     bad, obits.size(), exp_bits.size());
        end
        checks++;
        if (wd_cnt != N || out_word !== last_r || overflow !== last_o) begin
            errors++;
            $display("FAIL b2b_final done=%0d out_word=%h ovf=%b required %0d %h %b",
                     wd_cnt, out_word, overflow, N, last_r, last_o);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_mode_change();
        test_overflow();
        test_stalls();
        test_sync();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/twos_complement_serial_word.md
# twos_complement_serial_word

Parametrised, word-framed bit-serial arithmetic unit: successor to our single-bit two's-complement Mealy machine. Accepts an LSB-first serial stream with a valid qualifier, frames it into WIDTH-bit words, and applies a per-word mode: pass, one's complement or two's complement. Produces a registered serial output, the assembled parallel result word, and a negation-overflow flag. Sits between a serial source (shift register or testbench driver) and parallel consumers in the datapath lab designs.

## Interface
- WIDTH, 16, bits per word (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- in_valid  input  1  in_bit is a valid stream bit this cycle; 0 = stall
- in_bit  input  1  serial data, LSB first
- mode  input  2  00 pass, 01 one's complement, 10 two's complement, 11 treated as 10; sampled on bit 0 of each word
- sync  input  1  synchronous word realign: drop partial word
- out_valid  output  1  out_bit valid (registered in_valid)
- out_bit  output  1  transformed bit, one cycle after its input
- word_done  output  1  one-cycle pulse with the last bit's out_valid
- out_word  output  WIDTH  last completed result word; bit i = i-th output bit
- overflow  output  1  last completed word was two's-mode negation of the most negative value (1 followed by WIDTH-1 zeros, MSB-first)

## Operation
- Bit counter bit_cnt (0..WIDTH-1) advances only on in_valid=1; wraps WIDTH-1 → 0 and completes a word.
- Mode register: loaded from mode on an accepted bit with bit_cnt=0; held for rest of word. Mid-word mode changes ignored.
- Two's-complement FSM, states SCAN and INVERT:
  - SCAN: out = in_bit; if in_bit=1 → INVERT.
  - INVERT: out = ~in_bit; stay.
  - Forced to SCAN at start of every word (bit_cnt=0 uses SCAN regardless of previous word).
- One's mode: out = ~in_bit; pass mode: out = in_bit. FSM still tracked but unused.
- Shift/assembly register: each output bit written at position bit_cnt; on word completion copied to out_word.
- Overflow: on MSB (bit_cnt=WIDTH-1), in two's mode, state=SCAN and in_bit=1 → overflow=1 for that word; else 0. Updated only at word completion, held until next completion.
- Stalls (in_valid=0): counter, FSM, mode, assembly hold; out_valid=0 next cycle; out_bit holds last value.
- sync=1: bit_cnt←0, FSM←SCAN, partial assembly discarded, no word_done. If in_valid=1 in same cycle, that bit is accepted as bit 0 of a new word (mode sampled).

## Timing
- Reset (reset=0, asynchronous): bit_cnt=0, FSM=SCAN, mode register=10, out_valid=0, out_bit=0, word_done=0, out_word=0, overflow=0. Release is synchronous to next clk edge as usual; first accepted bit after release is bit 0.
- Reset mid-word: partial word lost, no word_done, out_word/overflow cleared.
- Latency: in_bit accepted at edge N → out_bit/out_valid valid after edge N (visible cycle N+1).
- word_done, out_word, overflow all change on the same edge as the last bit's out_valid; word_done high exactly one cycle unless the next word's last bit is accepted back-to-back (WIDTH=… never consecutive since WIDTH≥2).
- Full throughput: one bit per clock; back-to-back words need no gap.

## Test plan
- WIDTH=16, mode=10, stream 0x5772 LSB-first, no stalls → out_word=0xA88E, overflow=0, word_done one pulse on 16th out_valid, out_bit sequence matches 0xA88E LSB-first.
- Same stream, mode=01 → 0xA88D; mode=00 → 0x5772; mode changed to 00 at bit 7 of a mode-10 word → still 0xA88E.
- 0x8000 mode=10 → out_word=0x8000, overflow=1; next word 0x0000 → out_word=0x0000, overflow=0; then 0x0001 → 0xFFFF.
- 0x5772 mode=10 with random in_valid=0 gaps (up to 3 cycles) → out_word=0xA88E, out_valid count=16, one word_done.
- 5 bits of 0xFFFF then sync=1 with in_valid=1, followed by 0x5772 (first bit on sync cycle) → single word_done, out_word=0xA88E.
- reset pulsed low asynchronously after bit 9 → all outputs 0 immediately; following full 0x0003 mode=10 → out_word=0xFFFD.
